// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-stage operand slice.
//   - default widths for data, ALU opcode, register index and stall counter
//   - alu_op_t    : ALU operation encodings
//   - id_ex_t     : fields captured in the ID/EX pipeline register
//   - fwd_sel_t   : operand source select produced by the hazard unit
//   - src_hazard(): "source depends on a pending write" test
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_OP_W   = 4;
  localparam int unsigned CPU_REG_W  = 5;
  localparam int unsigned CPU_CNT_W  = 16;

  typedef enum logic [CPU_OP_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_NOR  = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_SLTU = 4'b1100,
    ALU_BLT  = 4'b1101,
    ALU_BGE  = 4'b1110
  } alu_op_t;

  typedef struct packed {
    logic                  valid;
    logic [CPU_REG_W-1:0]  rs1;
    logic [CPU_REG_W-1:0]  rs2;
    logic [CPU_REG_W-1:0]  rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic [CPU_DATA_W-1:0] rs1_data;
    logic [CPU_DATA_W-1:0] rs2_data;
    logic [CPU_DATA_W-1:0] imm;
    logic                  alu_src;
    alu_op_t               alu_op;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_hazard(input logic                 used,
                                      input logic                 valid,
                                      input logic [CPU_REG_W-1:0] src,
                                      input logic [CPU_REG_W-1:0] rd,
                                      input logic                 we);
    return used && valid && we && (rd == src) && (rd != '0);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational RAW hazard detection and forward-select generation.
// Build option: FORWARDING_EN
//   defined   - EX sources may be forwarded from EX/MEM or MEM/WB; only a
//               load in EX feeding the ID instruction stalls.
//   undefined - no forwarding; any pending write (EX, EX/MEM, MEM/WB) to an
//               ID source stalls.
// Ports:
//   i_id_*     : instruction in decode (valid, source indices, source use)
//   i_ex_*     : instruction in EX (valid, sources, rd, gated write/load bits)
//   i_exmem_*  : EX/MEM destination and write enable
//   i_memwb_*  : MEM/WB destination and write enable
//   i_flush    : redirect; suppresses the stall
//   o_id_stall : hold PC and IF/ID, bubble EX
//   o_fwd_a/b  : operand source select for EX rs1 / rs2
module hazard_unit
  import cpu_pkg::*;
(
  input  logic                 i_id_valid,
  input  logic [CPU_REG_W-1:0] i_id_rs1,
  input  logic [CPU_REG_W-1:0] i_id_rs2,
  input  logic                 i_id_uses_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic                 i_ex_valid,
  input  logic [CPU_REG_W-1:0] i_ex_rs1,
  input  logic [CPU_REG_W-1:0] i_ex_rs2,
  input  logic                 i_ex_uses_rs1,
  input  logic                 i_ex_uses_rs2,
  input  logic [CPU_REG_W-1:0] i_ex_rd,
  input  logic                 i_ex_reg_write,
  input  logic                 i_ex_mem_read,
  input  logic [CPU_REG_W-1:0] i_exmem_rd,
  input  logic                 i_exmem_reg_write,
  input  logic [CPU_REG_W-1:0] i_memwb_rd,
  input  logic                 i_memwb_reg_write,
  input  logic                 i_flush,
  output logic                 o_id_stall,
  output fwd_sel_t             o_fwd_a,
  output fwd_sel_t             o_fwd_b
);

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic w_id_ex_hz, w_id_exmem_hz, w_id_memwb_hz, w_stall_raw;
  logic w_a_exmem, w_a_memwb, w_b_exmem, w_b_memwb;

  // ID sources against each downstream stage (i_ex_reg_write is already
  // gated by EX valid, so a bubble never hazards).
  assign w_id_ex_hz =
      src_hazard(i_id_uses_rs1, i_id_valid, i_id_rs1, i_ex_rd, i_ex_reg_write) |
      src_hazard(i_id_uses_rs2, i_id_valid, i_id_rs2, i_ex_rd, i_ex_reg_write);
  assign w_id_exmem_hz =
      src_hazard(i_id_uses_rs1, i_id_valid, i_id_rs1, i_exmem_rd, i_exmem_reg_write) |
      src_hazard(i_id_uses_rs2, i_id_valid, i_id_rs2, i_exmem_rd, i_exmem_reg_write);
  assign w_id_memwb_hz =
      src_hazard(i_id_uses_rs1, i_id_valid, i_id_rs1, i_memwb_rd, i_memwb_reg_write) |
      src_hazard(i_id_uses_rs2, i_id_valid, i_id_rs2, i_memwb_rd, i_memwb_reg_write);

  assign w_stall_raw = FWD_EN ? (w_id_ex_hz & i_ex_mem_read)
                              : (w_id_ex_hz | w_id_exmem_hz | w_id_memwb_hz);
  assign o_id_stall  = w_stall_raw & ~i_flush;

  // EX sources against the stages ahead; EX/MEM is the younger result.
  assign w_a_exmem = src_hazard(i_ex_uses_rs1, i_ex_valid, i_ex_rs1, i_exmem_rd, i_exmem_reg_write);
  assign w_a_memwb = src_hazard(i_ex_uses_rs1, i_ex_valid, i_ex_rs1, i_memwb_rd, i_memwb_reg_write);
  assign w_b_exmem = src_hazard(i_ex_uses_rs2, i_ex_valid, i_ex_rs2, i_exmem_rd, i_exmem_reg_write);
  assign w_b_memwb = src_hazard(i_ex_uses_rs2, i_ex_valid, i_ex_rs2, i_memwb_rd, i_memwb_reg_write);

  assign o_fwd_a = !FWD_EN   ? FWD_NONE  :
                   w_a_exmem ? FWD_EXMEM :
                   w_a_memwb ? FWD_MEMWB : FWD_NONE;
  assign o_fwd_b = !FWD_EN   ? FWD_NONE  :
                   w_b_exmem ? FWD_EXMEM :
                   w_b_memwb ? FWD_MEMWB : FWD_NONE;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand resolution for the execute-stage ALU.
// Build option: FORWARDING_EN (see hazard_unit) selects forwarding vs.
// stall-on-any-hazard operation.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   id_*               : decoded instruction fields and register file data
//   flush              : branch redirect, kills the instruction entering EX
//   exmem_*, memwb_*   : destination/write-enable/result of later stages
//   id_stall           : hold PC and IF/ID this cycle
//   SrcA, SrcB, Operation : ALU inputs
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
//                      : EX slot contents passed on to EX/MEM
//   stall_count        : saturating count of stall cycles
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = CPU_DATA_W,
  parameter int unsigned OPCODE_LENGTH = CPU_OP_W,
  parameter int unsigned REG_ADDR_W    = CPU_REG_W,
  parameter int unsigned CNT_W         = CPU_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     id_stall,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [CNT_W-1:0]         stall_count
);

  id_ex_t                  r_ex;
  id_ex_t                  w_id_fields;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic                    w_id_stall;
  logic                    w_ex_reg_write, w_ex_mem_read, w_ex_mem_write;
  fwd_sel_t                w_fwd_a, w_fwd_b;
  logic [DATA_WIDTH-1:0]   w_rs1_res, w_rs2_res;

  assign w_id_fields = '{
    valid:     id_valid,
    rs1:       id_rs1,
    rs2:       id_rs2,
    rd:        id_rd,
    uses_rs1:  id_uses_rs1,
    uses_rs2:  id_uses_rs2,
    rs1_data:  id_rs1_data,
    rs2_data:  id_rs2_data,
    imm:       id_imm,
    alu_src:   id_alu_src,
    alu_op:    alu_op_t'(id_alu_op),
    reg_write: id_reg_write,
    mem_read:  id_mem_read,
    mem_write: id_mem_write
  };

  // Control bits of a bubble must never reach memory or the register file.
  assign w_ex_reg_write = r_ex.valid & r_ex.reg_write;
  assign w_ex_mem_read  = r_ex.valid & r_ex.mem_read;
  assign w_ex_mem_write = r_ex.valid & r_ex.mem_write;

  hazard_unit u_hazard (
    .i_id_valid        (id_valid),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_uses_rs1     (id_uses_rs1),
    .i_id_uses_rs2     (id_uses_rs2),
    .i_ex_valid        (r_ex.valid),
    .i_ex_rs1          (r_ex.rs1),
    .i_ex_rs2          (r_ex.rs2),
    .i_ex_uses_rs1     (r_ex.uses_rs1),
    .i_ex_uses_rs2     (r_ex.uses_rs2),
    .i_ex_rd           (r_ex.rd),
    .i_ex_reg_write    (w_ex_reg_write),
    .i_ex_mem_read     (w_ex_mem_read),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_flush           (flush),
    .o_id_stall        (w_id_stall),
    .o_fwd_a           (w_fwd_a),
    .o_fwd_b           (w_fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_stall_cnt <= '0;
    end else begin
      // A bubble only clears valid; the stale fields are masked downstream.
      if (flush || w_id_stall) begin
        r_ex.valid <= 1'b0;
      end else begin
        r_ex <= w_id_fields;
      end
      if (w_id_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rs1_res = r_ex.rs1_data;
    case (w_fwd_a)
      FWD_EXMEM: w_rs1_res = exmem_result;
      FWD_MEMWB: w_rs1_res = memwb_result;
      default:   w_rs1_res = r_ex.rs1_data;
    endcase
  end

  always_comb begin
    w_rs2_res = r_ex.rs2_data;
    case (w_fwd_b)
      FWD_EXMEM: w_rs2_res = exmem_result;
      FWD_MEMWB: w_rs2_res = memwb_result;
      default:   w_rs2_res = r_ex.rs2_data;
    endcase
  end

  assign id_stall      = w_id_stall;
  assign SrcA          = w_rs1_res;
  assign SrcB          = r_ex.alu_src ? r_ex.imm : w_rs2_res;
  assign Operation     = r_ex.alu_op;
  assign ex_valid      = r_ex.valid;
  assign ex_rd         = r_ex.rd;
  assign ex_reg_write  = w_ex_reg_write;
  assign ex_mem_read   = w_ex_mem_read;
  assign ex_mem_write  = w_ex_mem_write;
  assign ex_store_data = w_rs2_res;
  assign stall_count   = r_stall_cnt;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-resolution logic, directly upstream of the execute-stage ALU.
- Captures decoded instruction fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by stalling.
- Drives the ALU's SrcA, SrcB and Operation inputs, and forwards store data and destination info to EX/MEM.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_W, 5, register index width
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  source/dest indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source
- id_rs1_data, id_rs2_data  in  DATA_WIDTH each  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_alu_src  in  1  1 = SrcB takes immediate
- id_alu_op  in  OPCODE_LENGTH  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- flush  in  1  branch redirect; kill ID and EX contents
- exmem_rd  in  REG_ADDR_W;  exmem_reg_write  in  1;  exmem_result  in  DATA_WIDTH
- memwb_rd  in  REG_ADDR_W;  memwb_reg_write  in  1;  memwb_result  in  DATA_WIDTH
- id_stall  out  1  hold PC and IF/ID this cycle
- SrcA, SrcB  out  DATA_WIDTH each  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- ex_valid  out  1  EX slot holds a real instruction
- ex_rd  out  REG_ADDR_W;  ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_store_data  out  DATA_WIDTH  resolved rs2 value for stores
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (synchronous): all EX registers cleared.
  - ex_valid=0; ex_rd=0; all control bits 0; Operation=0000; captured data 0; stall_count=0.
  - id_stall is combinational and is 0 while ex_valid=0.
- Capture: each rising edge with no stall and no flush, EX registers load the id_* fields.
  - ex_valid <= id_valid.
  - Latency is 1 cycle from decode to ALU operands.
- Bubble gating: when ex_valid=0, ex_reg_write, ex_mem_read and ex_mem_write are driven 0 regardless of captured bits.
- Hazard definition: an ID source hazards against a stage when all of the following hold:
  - the source is used (id_uses_rsN),
  - id_valid=1,
  - that stage's rd equals the source index and is nonzero,
  - that stage's write-enable is 1.
- Load-use stall: hazard against EX while ex_mem_read=1.
  - id_stall=1.
  - The EX slot is loaded with a bubble (ex_valid=0), not the ID fields.
- Forwarding mux, separately for rs1 and rs2, in priority order:
  - EX/MEM match -> exmem_result;
  - else MEM/WB match -> memwb_result;
  - else captured register data.
  - Index 0 is never forwarded; it reads captured data, which the register file already returns as 0.
- SrcA = resolved rs1. SrcB = captured immediate when the captured alu_src=1, else resolved rs2. ex_store_data = resolved rs2 always.
- Flush: next edge sets ex_valid=0.
  - Flush has priority over stall; id_stall is forced 0 during flush.
- stall_count increments on every cycle with id_stall=1 and saturates at all-ones. It does not wrap.
- Reset asserted mid-stall: stall is dropped and counter cleared on the same edge.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: forwarding as described; only load-use stalls.
- Undefined: no forwarding paths; SrcA and SrcB always use captured data.
  - id_stall=1 on any hazard against the EX (any ex_reg_write, not only loads), EX/MEM or MEM/WB stages.
  - Each stall cycle inserts a bubble.

Decomposition:
- Shared package cpu_pkg holds:
  - widths;
  - alu_op_t enum with codes AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SLT 0101, XOR 0110, SRL 0111, SRA 1000, NOR 1001, BEQ 1010, BNE 1011, BLT 1101, BGE 1110, SLTU 1100;
  - id_ex_t struct of the captured fields.
- One sub-module, hazard_unit: combinational hazard detection and forward-select generation. It is instantiated once.

Test Plan:
- Back-to-back dependency: ADD x5 (result 7), then SUB x6,x5,x5 with exmem_rd=5, exmem_result=7, reg file data 0 -> SrcA=SrcB=7, Operation=0011, no stall.
- Double match: exmem_rd=memwb_rd=3, exmem_result=0xA, memwb_result=0xB -> SrcA=0xA (EX/MEM priority).
- Load-use: LW x4 in EX, next instruction reads x4 -> id_stall=1 for exactly 1 cycle, ex_valid=0 that cycle, stall_count=1.
- x0 guard: exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF, rs1=0 -> SrcA=0.
- Flush during load-use stall -> id_stall=0, next ex_valid=0, counter unchanged.
- FORWARDING_EN undefined: ADD x5 then ADD x7,x5,x1 -> 3 stall cycles, stall_count=3, then SrcA equals the register-file data.
